// File: rtl/mealy_rit_pkg.sv
// Shared definitions for the delayed Mealy sequence recognizer.
package mealy_rit_pkg;

    localparam int N_DEF      = 4;
    localparam int K_DEF      = 3;
    localparam int CW_DEF     = 8;
    localparam int STAR_W_DEF = $clog2(K_DEF);

    // Classification of one clock edge as seen by the detector.
    typedef enum logic [1:0] {
        EV_HOLD    = 2'd0,
        EV_ADVANCE = 2'd1,
        EV_MATCH   = 2'd2
    } step_ev_t;

    // Width of the prefix-match state for a sequence of length k.
    function automatic int star_w(input int k);
        return (k < 2) ? 1 : $clog2(k);
    endfunction

    // Saturating increment of a w-bit counter held in the low bits of v.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v == max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mealy_seq_detector_rit_prefix_match.sv
// Combinational suffix/prefix matcher: finds the longest pattern prefix that
// ends at the incoming symbol, bounded by the current state plus one.
module prefix_match
    import mealy_rit_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int K  = K_DEF,
    parameter int SW = star_w(K),
    parameter int JW = $clog2(K + 1)
) (
    input  logic [(K-1)*N-1:0] i_hist,
    input  logic [N-1:0]       i_x,
    input  logic [K*N-1:0]     i_pattern,
    input  logic [SW-1:0]      i_star,
    output logic [JW-1:0]      o_j_next,
    output logic               o_match,
    output logic [SW-1:0]      o_j_fallback
);

    // w_win[0] is the incoming symbol, w_win[m] the symbol m accepts ago.
    logic [N-1:0] w_win [K];
    logic [K:1]   w_ok;

    // Build the window of the most recent K symbols, newest first.
    always_comb begin
        w_win[0] = i_x;
        for (int m = 1; m < K; m++) begin
            w_win[m] = i_hist[(m-1)*N +: N];
        end
    end

    // w_ok[j]: the last j symbols equal pattern symbols 0..j-1.
    always_comb begin
        w_ok = '0;
        for (int j = 1; j <= K; j++) begin
            w_ok[j] = 1'b1;
            for (int m = 0; m < j; m++) begin
                if (w_win[m] != i_pattern[(j-1-m)*N +: N]) begin
                    w_ok[j] = 1'b0;
                end
            end
        end
    end

    // Pick the largest admissible length; j <= star+1 keeps stale history out.
    always_comb begin
        o_j_next     = '0;
        o_j_fallback = '0;
        for (int j = 1; j <= K; j++) begin
            if (w_ok[j] && (j <= int'(i_star) + 1)) begin
                o_j_next = JW'(j);
            end
            if (w_ok[j] && (j < K)) begin
                o_j_fallback = SW'(j);
            end
        end
    end

    assign o_match = (int'(o_j_next) == K);

endmodule

// File: rtl/mealy_seq_detector_rit.sv
// Delayed Mealy sequence recognizer with overlap control, input qualifier
// and saturating match counter. Outputs come straight from registers.
//
//   r_star | meaning
//   -------+---------------------------------------------------------
//   0      | no pattern prefix matches the recent accepted symbols
//   1..K-1 | the last r_star accepted symbols equal pattern[0..r_star-1]
module mealy_seq_detector_rit
    import mealy_rit_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int K  = K_DEF,
    parameter int CW = CW_DEF
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   x,
    input  logic           x_valid,
    input  logic [K*N-1:0] pattern,
    input  logic           overlap,
    output logic           z,
    output logic [CW-1:0]  match_count
);

    localparam int SW = star_w(K);
    localparam int JW = $clog2(K + 1);
    localparam int HW = (K - 1) * N;

    logic [SW-1:0] r_star;
    logic [HW-1:0] r_hist;
    logic          r_z;
    logic [CW-1:0] r_cnt;

    logic [JW-1:0] w_j_next;
    logic          w_match;
    logic [SW-1:0] w_j_fb;
    step_ev_t      w_ev;
    logic [SW-1:0] w_star_nxt;
    logic [HW-1:0] w_hist_nxt;
    logic          w_z_nxt;
    logic [CW-1:0] w_cnt_nxt;

    prefix_match #(
        .N  (N),
        .K  (K),
        .SW (SW),
        .JW (JW)
    ) u_prefix_match (
        .i_hist       (r_hist),
        .i_x          (x),
        .i_pattern    (pattern),
        .i_star       (r_star),
        .o_j_next     (w_j_next),
        .o_match      (w_match),
        .o_j_fallback (w_j_fb)
    );

    // Classify this edge: idle, ordinary advance, or completed match.
    always_comb begin
        w_ev = EV_HOLD;
        if (x_valid) begin
            w_ev = w_match ? EV_MATCH : EV_ADVANCE;
        end
    end

    // Next-state and registered-output values for the edge class.
    always_comb begin
        w_star_nxt = r_star;
        w_hist_nxt = r_hist;
        w_z_nxt    = 1'b0;
        w_cnt_nxt  = r_cnt;
        case (w_ev)
            EV_ADVANCE: begin
                w_star_nxt = w_j_next[SW-1:0];
                w_hist_nxt = (r_hist << N) | HW'(x);
            end
            EV_MATCH: begin
                w_star_nxt = overlap ? w_j_fb : '0;
                w_hist_nxt = (r_hist << N) | HW'(x);
                w_z_nxt    = 1'b1;
                w_cnt_nxt  = CW'(sat_inc(32'(r_cnt), CW));
            end
            default: ;
        endcase
    end

    // State and output registers; history is left unreset since the
    // star+1 bound never lets stale entries influence a match.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_star <= '0;
            r_z    <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_star <= w_star_nxt;
            r_hist <= w_hist_nxt;
            r_z    <= w_z_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign z           = r_z;
    assign match_count = r_cnt;

endmodule

// File: doc/mealy_seq_detector_rit.md
# mealy_seq_detector_rit

Parametrised, non-transparent (delayed) Mealy sequence recognizer. Each accepted input symbol advances an internal prefix-match state `STAR`. The output register `OUTR` is loaded on the same clock edge as `STAR`, from the input and state that were present before that edge, so `z` never depends combinationally on `x`. The block generalises the single-machine delayed Mealy template with:
- programmable symbol width, sequence length and pattern;
- overlap / non-overlap detection modes;
- an input-valid qualifier;
- a saturating match counter.

## Interface
Parameters:
- `N`, 4: symbol width in bits.
- `K`, 3: sequence length in symbols, K ≥ 2.
- `CW`, 8: width of the match counter.

Ports:
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset, sampled on the rising edge of `clock`.
- `x`  in  N  input symbol.
- `x_valid`  in  1  `x` is consumed on an edge only when this is 1.
- `pattern`  in  K*N  target sequence; bits [N-1:0] hold the first symbol, [K*N-1:(K-1)*N] the last.
- `overlap`  in  1  1 = overlapping matches allowed; 0 = restart after each match.
- `z`  out  1  registered match pulse (`OUTR`).
- `match_count`  out  CW  number of matches, saturating.

## Operation
- `STAR` ∈ {0..K-1} is the length of the longest pattern prefix equal to the most recent accepted symbols.
- `hist` holds the last K-1 accepted symbols.
- Next-state rule on an accepted symbol:
  - `j` = largest value ≤ `STAR`+1 such that the last j symbols (`hist` followed by `x`) equal `pattern` symbols 0..j-1.
  - If j < K: `STAR` <= j, `OUTR` <= 0.
  - If j == K (match): `OUTR` <= 1; `match_count` increments unless it is all ones.
    - If `overlap` = 1: `STAR` <= largest proper j' < K satisfying the same suffix/prefix condition.
    - If `overlap` = 0: `STAR` <= 0.
- The bound j ≤ `STAR`+1 makes `hist` contents beyond `STAR` irrelevant, so `hist` needs no reset.
- `x_valid` = 0: `STAR`, `hist` and `match_count` hold; `OUTR` <= 0.
- `reset` = 1: `STAR` <= 0, `OUTR` <= 0, `match_count` <= 0. Reset has priority over `x_valid`; a sequence in progress is discarded.
- `overlap` is sampled on every accepted edge and may change at any time.
- `pattern` changes only while `reset` = 1.

## Timing
- Latency: `z` = 1 for exactly one cycle, in the cycle after the edge that accepted the last symbol of a match.
- Back-to-back matches produce `z` high on consecutive cycles with no bubble. Example: pattern A,A with `overlap` = 1 and input A,A,A gives `z` pulses on two consecutive cycles.
- `match_count` updates on the same edge as `z` rises.
- Reset values: `z` = 0, `match_count` = 0.
- Reset asserted on the edge that completes a match: no pulse and no count.
- Both outputs are driven directly from registers; there is no combinational path from any input to any output.

## Structure
- Shared package `mealy_rit_pkg`:
  - default values for N, K, CW;
  - `STAR` encoding width `$clog2(K)`;
  - function `sat_inc` for the counter.
- One sub-module, `prefix_match`: purely combinational. Inputs: `hist`, `x`, `pattern`, `STAR`. Outputs: `j_next`, `match`, `j_fallback`.
- Top level holds `STAR`, `hist`, `OUTR` and `match_count`, all updated in a single clocked block with nonblocking assignments.

## Test plan
Default parameters N=4, K=3, `pattern` = A,B,A (symbols 4'hA, 4'hB, 4'hA); `x_valid` = 1 unless stated.
- `overlap` = 1, `x` = A,B,A,B,A → `z` high in the cycles after the 3rd and 5th edges; `match_count` = 2.
- `overlap` = 0, same input → `z` high only after the 3rd edge; `match_count` = 1.
- Fallback: `x` = A,A,B,A → `STAR` sequence 1,1,2; `z` high once, after the 4th edge.
- Valid gaps: A, then `x_valid` = 0 for 3 cycles with `x` = B, then B, A → `z` stays 0 during the gaps and pulses once after the final A.
- Reset mid-sequence: A,B, then `reset` = 1 for one edge, then A → `z` = 0 throughout; `match_count` = 0; `STAR` = 1 at the end.
- Saturation with CW = 2, `overlap` = 1: input A,B,A,B,A,B,A,B,A,B,A (5 matches) → `match_count` = 3; `z` still pulses 5 times.
